// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down sweep sequencer.
// State encoding and counter direction codes.
package updown_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic UP_DIR   = 1'b0;
  localparam logic DOWN_DIR = 1'b1;

endpackage

// File: rtl/sweep_counter.sv
// Loadable up/down counter stepping by one when enabled.
// Load takes priority over the step.
module sweep_counter
  import updown_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (dir_i == DOWN_DIR) count_d = count_q - WIDTH'(1);
      else                   count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangular lo->hi->lo sweep sequencer with start/busy/done handshake.
// Optional UPDOWN_SWEEP_PAUSE_EN adds a pause input that stalls the sweep.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [NW-1:0]    n_sweeps,
  input  logic             abort,
`ifdef UPDOWN_SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic [NW-1:0]    sweep_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [NW-1:0]    n_q, n_d;
  logic [NW-1:0]    sweep_q, sweep_d;
  logic             err_q, err_d;
  logic             ld, en, dir, stall;
  logic [NW-1:0]    sweep_inc;

`ifdef UPDOWN_SWEEP_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign sweep_inc = sweep_q + NW'(1);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    sweep_d = sweep_q;
    err_d   = err_q;
    ld      = 1'b0;
    en      = 1'b0;
    dir     = UP_DIR;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (n_sweeps != '0)) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            ld      = 1'b1;
            sweep_d = '0;
            err_d   = 1'b0;
            state_d = UP;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!stall) begin
          en = 1'b1;
          if (count == hi_q) begin
            dir     = DOWN_DIR;
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!stall) begin
          if (count != lo_q) begin
            en  = 1'b1;
            dir = DOWN_DIR;
          end else begin
            sweep_d = sweep_inc;
            if (sweep_inc == n_q) begin
              state_d = DONE;
            end else begin
              // Turnaround at lo steps straight to lo+1
              en      = 1'b1;
              state_d = UP;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end

  sweep_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ld),
    .load_val_i(lo),
    .en_i      (en),
    .dir_i     (dir),
    .count_o   (count)
  );

  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign done      = (state_q == DONE);
  assign up_down   = (state_q == DOWN) ? DOWN_DIR : UP_DIR;
  assign err       = err_q;
  assign sweep_cnt = sweep_q;

endmodule
